// File: rtl/hazard_sequencer.sv
// Hazard/sequencing control for the 5-stage core: load-use stall, branch/jump
// squash, and a drain-then-handshake sequence for SYSCALL.
// Ports: clk, reset (sync, active-high); ID fields id_rs/id_rt/id_uses_rt,
//   id_jump, id_syscall; EX fields ex_mem_read/ex_rt, br_taken; sys_done.
//   Outputs pc_write, ifid_write, ifid_flush, idex_bubble, syscall_go, busy.
// Optional: define HAZARD_STALL_COUNT_EN to add stall_cnt[CNT_W-1:0], a
//   saturating count of cycles with pc_write low.
module hazard_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             br_taken,
  input  logic             id_jump,
  input  logic             id_syscall,
  input  logic             sys_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             syscall_go,
  output logic             busy
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // SYS is split so syscall_go fires only on its first cycle.
  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SYS_GO,
    SYS_WAIT
  } state_t;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES - 1);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || CNT_W < 1) begin : g_bad_cfg
    $error("hazard_sequencer: DRAIN_CYCLES must be 1..15, CNT_W >= 1");
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load_use;

  // $zero never carries a real dependency.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) ||
                     (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    syscall_go  = 1'b0;
    busy        = (state != RUN);
    if (reset) begin
      state_nxt   = RUN;
      cnt_nxt     = 4'd0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      busy        = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_syscall) begin
            // Freeze starts on the entry cycle itself.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_nxt     = DRAIN_LD;
            state_nxt   = DRAIN;
          end else if (id_jump) begin
            ifid_flush  = 1'b1;
          end
        end
        DRAIN: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt == 4'd0) begin
            state_nxt = SYS_GO;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        SYS_GO, SYS_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          syscall_go  = (state == SYS_GO);
          state_nxt   = SYS_WAIT;
          if (sys_done) begin
            // Resume fetch and drop the consumed SYSCALL from IF/ID.
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            state_nxt  = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: per-scenario tasks push expected
// output vectors into a scoreboard queue and pop/compare each cycle.
module tb_hazard_sequencer;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       jmp;
    logic       sc;
    logic       done;
  } in_t;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, syscall_go, busy}
  localparam logic [5:0] RST    = 6'b001101;
  localparam logic [5:0] NORM   = 6'b110000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] BRANCH = 6'b111100;
  localparam logic [5:0] JUMP   = 6'b111000;
  localparam logic [5:0] ENTRY  = 6'b000100;
  localparam logic [5:0] DRN    = 6'b000101;
  localparam logic [5:0] GO     = 6'b000111;
  localparam logic [5:0] WAITS  = 6'b000101;
  localparam logic [5:0] DONE   = 6'b111101;
  localparam logic [5:0] GODONE = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, br_taken;
  logic       id_jump, id_syscall, sys_done;
  logic       pc_write, ifid_write, ifid_flush;
  logic       idex_bubble, syscall_go, busy;
`ifdef HAZARD_STALL_COUNT_EN
  logic [3:0] stall_cnt;
  int         cnt_q[$];
`endif
  logic [5:0] obs;
  logic [5:0] exp_q[$];
  int         vectors = 0;
  int         errors  = 0;

  assign obs = {pc_write, ifid_write, ifid_flush,
                idex_bubble, syscall_go, busy};

  always #5 clk = ~clk;

  hazard_sequencer #(
    .DRAIN_CYCLES(3),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt),
    .br_taken(br_taken),
    .id_jump(id_jump),
    .id_syscall(id_syscall),
    .sys_done(sys_done),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .syscall_go(syscall_go),
    .busy(busy)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic in_t mk(
    input logic rst, input logic [4:0] rs, input logic [4:0] rt,
    input logic urt, input logic mr, input logic [4:0] ert,
    input logic br, input logic jmp, input logic sc, input logic done);
    in_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.mr = mr;
    v.ert = ert; v.br = br; v.jmp = jmp; v.sc = sc; v.done = done;
    return v;
  endfunction

  task automatic apply(input in_t v);
    reset       = v.rst;
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_uses_rt  = v.urt;
    ex_mem_read = v.mr;
    ex_rt       = v.ert;
    br_taken    = v.br;
    id_jump     = v.jmp;
    id_syscall  = v.sc;
    sys_done    = v.done;
  endtask

  task automatic test_reset();
    in_t        v[3];
    logic [5:0] e[3];
    logic [5:0] want;
    v[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[0] = RST;
    v[1] = mk(1, 8, 0, 0, 1, 8, 1, 1, 1, 1); e[1] = RST;
    v[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = NORM;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset[%0d] got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_load_use();
    in_t        v[6];
    logic [5:0] e[6];
    logic [5:0] want;
    v[0] = mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0); e[0] = STALL;
    v[1] = mk(0, 8, 0, 0, 0, 8, 0, 0, 0, 0); e[1] = NORM;
    v[2] = mk(0, 3, 8, 1, 1, 8, 0, 0, 0, 0); e[2] = STALL;
    v[3] = mk(0, 3, 8, 0, 1, 8, 0, 0, 0, 0); e[3] = NORM;
    v[4] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); e[4] = NORM;
    v[5] = mk(0, 9, 9, 1, 1, 8, 0, 0, 0, 0); e[5] = NORM;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL load_use[%0d] got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_branch();
    in_t        v[3];
    logic [5:0] e[3];
    logic [5:0] want;
    v[0] = mk(0, 8, 0, 0, 1, 8, 1, 0, 0, 0); e[0] = BRANCH;
    v[1] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); e[1] = BRANCH;
    v[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = NORM;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL branch[%0d] got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_jump();
    in_t        v[5];
    logic [5:0] e[5];
    logic [5:0] want;
    v[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[0] = JUMP;
    v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[1] = NORM;
    v[2] = mk(0, 8, 0, 0, 1, 8, 0, 1, 0, 0); e[2] = STALL;
    v[3] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0); e[3] = BRANCH;
    v[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = NORM;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL jump[%0d] got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_syscall();
    in_t        v[9];
    logic [5:0] e[9];
    logic [5:0] want;
    v[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[0] = ENTRY;
    v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[1] = DRN;
    v[2] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); e[2] = DRN;
    v[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[3] = DRN;
    v[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[4] = GO;
    v[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[5] = WAITS;
    v[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); e[6] = WAITS;
    v[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[7] = DONE;
    v[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[8] = NORM;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL syscall[cyc %0d] got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_t        v[13];
    logic [5:0] e[13];
    logic [5:0] want;
    for (int i = 0; i < 13; i++) begin
      v[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    e[0] = ENTRY; e[1] = DRN; e[2] = DRN; e[3] = DRN;
    v[4].done = 1'b1; e[4] = GODONE;
    v[5].sc = 1'b0; e[5] = NORM;
    e[6] = ENTRY; e[7] = DRN; e[8] = DRN; e[9] = DRN;
    e[10] = GO;
    v[11].done = 1'b1; e[11] = DONE;
    v[12].sc = 1'b0; e[12] = NORM;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid_sys();
    in_t        v[10];
    logic [5:0] e[10];
    logic [5:0] want;
    for (int i = 0; i < 10; i++) begin
      v[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    v[0].sc = 1'b1; e[0] = ENTRY;
    e[1] = DRN; e[2] = DRN; e[3] = DRN;
    e[4] = GO; e[5] = WAITS;
    v[6].rst = 1'b1; e[6] = RST;
    e[7] = NORM;
    v[8].done = 1'b1; e[8] = NORM;
    e[9] = NORM;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back(e[i]);
      #4;
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset_mid_sys[%0d] got %b want %b", i, obs, want);
      end
    end
  endtask

`ifdef HAZARD_STALL_COUNT_EN
  task automatic test_stall_cnt();
    in_t v;
    int  model;
    int  want;
    @(negedge clk);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      v = (i < 20) ? mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0)
                   : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(v);
      cnt_q.push_back(model);
      #4;
      want = cnt_q.pop_front();
      vectors++;
      if (int'(stall_cnt) !== want) begin
        errors++;
        $display("FAIL stall_cnt[%0d] got %0d want %0d", i, stall_cnt, want);
      end
      if (i < 20 && model < 15) model++;
    end
    @(negedge clk);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cnt_q.push_back(0);
    #4;
    want = cnt_q.pop_front();
    vectors++;
    if (int'(stall_cnt) !== want) begin
      errors++;
      $display("FAIL stall_cnt_reset got %0d want %0d", stall_cnt, want);
    end
  endtask
`endif

  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_syscall();
    test_back_to_back();
    test_reset_mid_sys();
`ifdef HAZARD_STALL_COUNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
